xyz_to_lms_transform: RTL and testbench

Converts a white-point XYZ triple into Bradford LMS cone responses for the chromatic adaptation path. It sits directly downstream of `cct_to_xyz_converter` and consumes its `xyz_out`/`xyz_valid` outputs. It performs the 3x3 Bradford matrix multiply with a single time-shared signed multiplier over 9 cycles, then presents a saturated Q16.16 LMS triple with a one-cycle valid pulse.

---
 rtl/xyz_to_lms_transform.sv | 140 ++++++++++++++
 tb/tb_xyz_to_lms_transform.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/xyz_to_lms_transform.sv
// Bradford XYZ -> LMS transform: a 3x3 fixed-point matrix multiply using one shared multiplier.
// Each transform takes nine MAC cycles and ends in a single lms_valid pulse.
module xyz_to_lms_transform #(
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [31:0] xyz_in [2:0],
  input  logic               xyz_valid,
  output logic signed [31:0] lms_out [2:0],
  output logic               lms_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int unsigned AccW = 66;

  localparam logic signed [AccW-1:0] SatMax = {{(AccW - 31){1'b0}}, {31{1'b1}}};
  localparam logic signed [AccW-1:0] SatMin = {{(AccW - 31){1'b1}}, {31{1'b0}}};

  typedef enum logic [0:0] {StIdle, StMac} state_e;

  state_e                 state_q;
  logic signed [31:0]     xin_q    [2:0];
  logic signed [31:0]     shadow_q [1:0];
  logic signed [AccW-1:0] acc_q;
  logic [1:0]             row_q;
  logic [1:0]             col_q;

  logic signed [31:0]     coef;
  logic signed [31:0]     xsel;
  logic [63:0]            coef_ext;
  logic [63:0]            xsel_ext;
  logic [63:0]            prod;
  logic signed [AccW-1:0] acc_sum;
  logic signed [AccW-1:0] acc_shift;
  logic signed [31:0]     row_result;

  // M_BFD in Q16.16, row-major.
  function automatic logic signed [31:0] coef_lookup(input logic [1:0] row, input logic [1:0] col);
    logic signed [31:0] c;
    case ({row, col})
      4'b00_00: c = 32'sd58661;
      4'b00_01: c = 32'sd17459;
      4'b00_10: c = -32'sd10578;
      4'b01_00: c = -32'sd49165;
      4'b01_01: c = 32'sd112296;
      4'b01_10: c = 32'sd2405;
      4'b10_00: c = 32'sd2549;
      4'b10_01: c = -32'sd4489;
      4'b10_10: c = 32'sd67476;
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    coef = coef_lookup(row_q, col_q);
    case (col_q)
      2'd0:    xsel = xin_q[0];
      2'd1:    xsel = xin_q[1];
      2'd2:    xsel = xin_q[2];
      default: xsel = '0;
    endcase
    // Low 64 bits of an unsigned product of sign-extended operands equal the signed product.
    coef_ext  = {{32{coef[31]}}, coef};
    xsel_ext  = {{32{xsel[31]}}, xsel};
    prod      = coef_ext * xsel_ext;
    acc_sum   = acc_q + $signed({{2{prod[63]}}, prod});
    acc_shift = acc_sum >>> FRAC_BITS;
    if (acc_shift > SatMax) begin
      row_result = 32'sh7FFF_FFFF;
    end else if (acc_shift < SatMin) begin
      row_result = 32'sh8000_0000;
    end else begin
      row_result = acc_shift[31:0];
    end
  end

  assign busy = (state_q == StMac);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      lms_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        xin_q[i]   <= '0;
        lms_out[i] <= '0;
      end
      for (int i = 0; i < 2; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      lms_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (xyz_valid) begin
            for (int i = 0; i < 3; i++) begin
              xin_q[i] <= xyz_in[i];
            end
            acc_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            state_q <= StMac;
          end
        end
        StMac: begin
          // Strobes during a transform are dropped; the in-flight data is untouched.
          if (xyz_valid) begin
            overrun <= 1'b1;
          end
          if (col_q == 2'd2) begin
            acc_q <= '0;
            col_q <= '0;
            if (row_q == 2'd2) begin
              lms_out[0] <= shadow_q[0];
              lms_out[1] <= shadow_q[1];
              lms_out[2] <= row_result;
              lms_valid  <= 1'b1;
              row_q      <= '0;
              state_q    <= StIdle;
            end else begin
              shadow_q[row_q[0]] <= row_result;
              row_q              <= row_q + 2'd1;
            end
          end else begin
            acc_q <= acc_sum;
            col_q <= col_q + 2'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_xyz_to_lms_transform.sv
// Directed bench for xyz_to_lms_transform: results, latency, saturation, overrun and reset abort.
// Expected values are hand-computed from the Bradford coefficient table.
module tb_xyz_to_lms_transform;

  logic               clk;
  logic               rst_n;
  logic signed [31:0] xyz_in  [2:0];
  logic               xyz_valid;
  logic signed [31:0] lms_out [2:0];
  logic               lms_valid;
  logic               busy;
  logic               overrun;

  int errors = 0;
  int checks = 0;

  xyz_to_lms_transform #(.FRAC_BITS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .xyz_in    (xyz_in),
    .xyz_valid (xyz_valid),
    .lms_out   (lms_out),
    .lms_valid (lms_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp, input int tol);
    checks++;
    assert ((obs >= exp - tol) && (obs <= exp + tol)) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic check_lms(input string tag, input logic signed [31:0] l,
                           input logic signed [31:0] m, input logic signed [31:0] s);
    check({tag, "_l"}, lms_out[0], l);
    check({tag, "_m"}, lms_out[1], m);
    check({tag, "_s"}, lms_out[2], s);
  endtask

  // Called at a falling edge; the strobe is sampled by the next rising edge.
  task automatic strobe(input logic signed [31:0] x, input logic signed [31:0] y,
                        input logic signed [31:0] z);
    xyz_in[0] = x;
    xyz_in[1] = y;
    xyz_in[2] = z;
    xyz_valid = 1'b1;
    @(negedge clk);
    xyz_valid = 1'b0;
    xyz_in[0] = 32'hDEAD_BEEF;
    xyz_in[1] = 32'h1234_5678;
    xyz_in[2] = 32'hA5A5_5A5A;
  endtask

  task automatic wait_valid(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (lms_valid === 1'b1) break;
    end
    check(tag, n, exp_cycles);
  endtask

  task automatic count_valids(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (lms_valid === 1'b1) cnt++;
    end
  endtask

  initial begin
    int vcnt;
    rst_n     = 1'b0;
    xyz_valid = 1'b0;
    for (int i = 0; i < 3; i++) xyz_in[i] = '0;
    repeat (2) @(negedge clk);
    check_lms("reset", 32'sd0, 32'sd0, 32'sd0);
    check("reset_valid", {31'b0, lms_valid}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_overrun", {31'b0, overrun}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unit X
    strobe(32'sh0001_0000, 32'sd0, 32'sd0);
    check("unitx_busy", {31'b0, busy}, 32'd1);
    wait_valid("unitx_latency", 9);
    check_lms("unitx", 32'sd58661, -32'sd49165, 32'sd2549);
    check("unitx_idle", {31'b0, busy}, 32'd0);

    // Back-to-back: strobe while lms_valid is high
    strobe(32'sd0, 32'sh0001_0000, 32'sd0);
    check("b2b_pulse_fall", {31'b0, lms_valid}, 32'd0);
    check("b2b_busy", {31'b0, busy}, 32'd1);
    check_lms("b2b_hold", 32'sd58661, -32'sd49165, 32'sd2549);
    wait_valid("b2b_latency", 9);
    check_lms("unity", 32'sd17459, 32'sd112296, -32'sd4489);
    check("b2b_overrun", {31'b0, overrun}, 32'd0);
    @(negedge clk);
    check("unity_pulse_fall", {31'b0, lms_valid}, 32'd0);

    // D65 white
    strobe(32'sd62290, 32'sd65536, 32'sd71358);
    wait_valid("d65_latency", 9);
    check_near("d65_l", lms_out[0], 32'sd61697, 4);
    check_near("d65_m", lms_out[1], 32'sd68185, 4);
    check_near("d65_s", lms_out[2], 32'sd71404, 4);

    // Positive saturation on L
    strobe(32'sh7FFF_0000, 32'sh7FFF_0000, 32'sd0);
    wait_valid("satp_latency", 9);
    check_lms("satp", 32'sh7FFF_FFFF, 32'sd2068613477, -32'sd63567980);

    // Negative saturation on M
    strobe(32'sd0, 32'sh8000_0000, 32'sd0);
    wait_valid("satn_latency", 9);
    check_lms("satn", -32'sd572096512, 32'sh8000_0000, 32'sd147095552);

    // Overrun: second strobe sampled four edges after the first
    strobe(32'sh0001_0000, 32'sd0, 32'sd0);
    repeat (3) @(negedge clk);
    check("ovr_before", {31'b0, overrun}, 32'd0);
    strobe(32'sd0, 32'sh0001_0000, 32'sd0);
    check("ovr_set", {31'b0, overrun}, 32'd1);
    wait_valid("ovr_latency", 5);
    check_lms("ovr_result", 32'sd58661, -32'sd49165, 32'sd2549);
    count_valids(15, vcnt);
    check("ovr_single_valid", vcnt, 32'd0);
    check("ovr_sticky", {31'b0, overrun}, 32'd1);

    // Reset in the middle of a D65 transform
    strobe(32'sd62290, 32'sd65536, 32'sd71358);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_lms("rst_mid", 32'sd0, 32'sd0, 32'sd0);
    check("rst_mid_valid", {31'b0, lms_valid}, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_overrun", {31'b0, overrun}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_valids(12, vcnt);
    check("rst_no_valid", vcnt, 32'd0);
    check("rst_idle", {31'b0, busy}, 32'd0);
    strobe(32'sh0001_0000, 32'sd0, 32'sd0);
    wait_valid("rst_unitx_latency", 9);
    check_lms("rst_unitx", 32'sd58661, -32'sd49165, 32'sd2549);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
